// File: rtl/axis_data_width_converter.sv
// ---------------------------------------------------------------------------
// axis_data_width_converter
//
// Byte-lane stream width converter. Narrow input beats are packed into wide
// output beats (upsize), wide input beats are split into narrow slices
// (downsize), or beats pass through a single register (equal widths). The
// input side carries no last flag; a beat whose keep is not all-ones closes
// a packet, and the output beat that carries its final byte has last = 1.
// Disabled bytes are always driven as zero on the output.
//
// Ports
//   i_clk           clock, all state updates on the rising edge
//   i_aresetn       synchronous reset, ACTIVE-HIGH despite the name
//   i_input_valid   upstream beat valid
//   o_input_ready   upstream beat accepted when valid & ready
//   i_input_data    upstream data, byte k = bits [8k+7:8k]
//   i_input_keep    upstream byte enables, contiguous from bit 0, never zero
//   o_output_valid  downstream beat valid (registered)
//   i_output_ready  downstream ready
//   o_output_last   final beat of a packet (registered)
//   o_output_data   downstream data (registered)
//   o_output_keep   downstream byte enables (registered)
// ---------------------------------------------------------------------------
module axis_data_width_converter #(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 64
) (
    input  logic                        i_clk,
    input  logic                        i_aresetn,
    input  logic                        i_input_valid,
    output logic                        o_input_ready,
    input  logic [INPUT_WIDTH-1:0]      i_input_data,
    input  logic [(INPUT_WIDTH-1)/8:0]  i_input_keep,
    output logic                        o_output_valid,
    input  logic                        i_output_ready,
    output logic                        o_output_last,
    output logic [OUTPUT_WIDTH-1:0]     o_output_data,
    output logic [(OUTPUT_WIDTH-1)/8:0] o_output_keep
);

    localparam int IK = INPUT_WIDTH / 8;

    // Zero every input byte whose keep bit is clear.
    function automatic logic [INPUT_WIDTH-1:0] mask_bytes(
        input logic [INPUT_WIDTH-1:0] data,
        input logic [IK-1:0]          keep
    );
        logic [INPUT_WIDTH-1:0] masked;
        masked = {INPUT_WIDTH{1'b0}};
        for (int b = 0; b < IK; b++) begin
            if (keep[b]) begin
                masked[8*b +: 8] = data[8*b +: 8];
            end else begin
                masked[8*b +: 8] = 8'h00;
            end
        end
        return masked;
    endfunction

    // Output register bank shared by all modes.
    logic                             out_valid_q, out_valid_d;
    logic                             out_last_q,  out_last_d;
    logic [OUTPUT_WIDTH-1:0]          out_data_q,  out_data_d;
    logic [(OUTPUT_WIDTH-1)/8:0]      out_keep_q,  out_keep_d;
    logic                             in_ready_s;
    logic                             in_fire_s;

    // Output register update; reset clears the whole output beat.
    always_ff @(posedge i_clk) begin
        if (i_aresetn) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {OUTPUT_WIDTH{1'b0}};
            out_keep_q  <= {((OUTPUT_WIDTH-1)/8+1){1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
        end
    end

    assign o_input_ready  = in_ready_s;
    assign o_output_valid = out_valid_q;
    assign o_output_last  = out_last_q;
    assign o_output_data  = out_data_q;
    assign o_output_keep  = out_keep_q;

    if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_upsize
        localparam int R  = OUTPUT_WIDTH / INPUT_WIDTH;
        localparam int OK = OUTPUT_WIDTH / 8;
        localparam int LW = (R > 1) ? $clog2(R) : 1;

        logic [OUTPUT_WIDTH-1:0] acc_data_q, acc_data_d;
        logic [OK-1:0]           acc_keep_q, acc_keep_d;
        logic [LW-1:0]           lane_q,     lane_d;
        logic [OUTPUT_WIDTH-1:0] merged_data_s;
        logic [OK-1:0]           merged_keep_s;
        logic [INPUT_WIDTH-1:0]  in_masked_s;
        logic                    in_partial_s;
        logic                    complete_s;

        // Accumulator and lane counter; reset drops any partial word.
        always_ff @(posedge i_clk) begin
            if (i_aresetn) begin
                acc_data_q <= {OUTPUT_WIDTH{1'b0}};
                acc_keep_q <= {OK{1'b0}};
                lane_q     <= {LW{1'b0}};
            end else begin
                acc_data_q <= acc_data_d;
                acc_keep_q <= acc_keep_d;
                lane_q     <= lane_d;
            end
        end

        // Pack the accepted beat into its lane and decide when the word is done.
        always_comb begin
            in_ready_s    = !i_aresetn && (!out_valid_q || i_output_ready);
            in_fire_s     = i_input_valid && in_ready_s;
            in_partial_s  = (i_input_keep != {IK{1'b1}});
            in_masked_s   = mask_bytes(i_input_data, i_input_keep);
            complete_s    = (lane_q == LW'(R - 1)) || in_partial_s;

            merged_data_s = acc_data_q;
            merged_keep_s = acc_keep_q;
            for (int l = 0; l < R; l++) begin
                if (lane_q == LW'(l)) begin
                    merged_data_s[l*INPUT_WIDTH +: INPUT_WIDTH] = in_masked_s;
                    merged_keep_s[l*IK +: IK]                   = i_input_keep;
                end else begin
                    merged_data_s[l*INPUT_WIDTH +: INPUT_WIDTH] = acc_data_q[l*INPUT_WIDTH +: INPUT_WIDTH];
                    merged_keep_s[l*IK +: IK]                   = acc_keep_q[l*IK +: IK];
                end
            end

            out_last_d = out_last_q;
            out_data_d = out_data_q;
            out_keep_d = out_keep_q;
            acc_data_d = acc_data_q;
            acc_keep_d = acc_keep_q;
            lane_d     = lane_q;
            if (out_valid_q && i_output_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end

            if (in_fire_s) begin
                if (complete_s) begin
                    // A completing beat may coincide with the drain of the previous word.
                    out_valid_d = 1'b1;
                    out_data_d  = merged_data_s;
                    out_keep_d  = merged_keep_s;
                    out_last_d  = in_partial_s;
                    acc_data_d  = {OUTPUT_WIDTH{1'b0}};
                    acc_keep_d  = {OK{1'b0}};
                    lane_d      = {LW{1'b0}};
                end else begin
                    acc_data_d  = merged_data_s;
                    acc_keep_d  = merged_keep_s;
                    lane_d      = lane_q + LW'(1'b1);
                end
            end else begin
                lane_d = lane_q;
            end
        end
    end else if (INPUT_WIDTH > OUTPUT_WIDTH) begin : g_downsize
        localparam int R  = INPUT_WIDTH / OUTPUT_WIDTH;
        localparam int OK = OUTPUT_WIDTH / 8;
        localparam int LW = (R > 1) ? $clog2(R) : 1;

        logic [INPUT_WIDTH-1:0]  hold_data_q, hold_data_d;
        logic [IK-1:0]           hold_keep_q, hold_keep_d;
        logic [LW-1:0]           slice_q,     slice_d;
        logic                    final_q,     final_d;
        logic [INPUT_WIDTH-1:0]  src_data_s;
        logic [IK-1:0]           src_keep_s;
        logic [IK:0]             src_keep_ext_s;
        logic [LW-1:0]           src_idx_s;
        logic                    src_partial_s;
        logic [OUTPUT_WIDTH-1:0] slice_data_s;
        logic [OK-1:0]           slice_keep_s;
        logic                    slice_final_s;

        // Held beat and slice pointer; reset discards the held beat.
        always_ff @(posedge i_clk) begin
            if (i_aresetn) begin
                hold_data_q <= {INPUT_WIDTH{1'b0}};
                hold_keep_q <= {IK{1'b0}};
                slice_q     <= {LW{1'b0}};
                final_q     <= 1'b0;
            end else begin
                hold_data_q <= hold_data_d;
                hold_keep_q <= hold_keep_d;
                slice_q     <= slice_d;
                final_q     <= final_d;
            end
        end

        // Select the next slice either from a newly captured beat or the held one.
        always_comb begin
            in_ready_s = !i_aresetn && (!out_valid_q || (i_output_ready && final_q));
            in_fire_s  = i_input_valid && in_ready_s;

            if (in_fire_s) begin
                src_data_s = mask_bytes(i_input_data, i_input_keep);
                src_keep_s = i_input_keep;
                src_idx_s  = {LW{1'b0}};
            end else begin
                src_data_s = hold_data_q;
                src_keep_s = hold_keep_q;
                src_idx_s  = slice_q + LW'(1'b1);
            end
            src_partial_s  = (src_keep_s != {IK{1'b1}});
            // Keep is contiguous, so a slice is the final non-empty one when the
            // first byte of the following slice is disabled (or there is none).
            src_keep_ext_s = {1'b0, src_keep_s};

            slice_data_s  = {OUTPUT_WIDTH{1'b0}};
            slice_keep_s  = {OK{1'b0}};
            slice_final_s = 1'b1;
            for (int r = 0; r < R; r++) begin
                if (src_idx_s == LW'(r)) begin
                    slice_data_s  = src_data_s[r*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                    slice_keep_s  = src_keep_s[r*OK +: OK];
                    slice_final_s = !src_keep_ext_s[(r+1)*OK];
                end else begin
                    slice_data_s  = slice_data_s;
                end
            end
        end

        // Emit slices one per handshake; capture the next beat on the final one.
        always_comb begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
            out_data_d  = out_data_q;
            out_keep_d  = out_keep_q;
            hold_data_d = hold_data_q;
            hold_keep_d = hold_keep_q;
            slice_d     = slice_q;
            final_d     = final_q;
            if (in_fire_s) begin
                hold_data_d = src_data_s;
                hold_keep_d = src_keep_s;
                slice_d     = {LW{1'b0}};
                out_valid_d = 1'b1;
                out_data_d  = slice_data_s;
                out_keep_d  = slice_keep_s;
                out_last_d  = slice_final_s && src_partial_s;
                final_d     = slice_final_s;
            end else if (out_valid_q && i_output_ready) begin
                if (final_q) begin
                    out_valid_d = 1'b0;
                end else begin
                    slice_d     = src_idx_s;
                    out_data_d  = slice_data_s;
                    out_keep_d  = slice_keep_s;
                    out_last_d  = slice_final_s && src_partial_s;
                    final_d     = slice_final_s;
                end
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end else begin : g_equal
        // Single register stage; a partial keep marks the end of a packet.
        always_comb begin
            in_ready_s = !i_aresetn && (!out_valid_q || i_output_ready);
            in_fire_s  = i_input_valid && in_ready_s;
            out_last_d = out_last_q;
            out_data_d = out_data_q;
            out_keep_d = out_keep_q;
            if (in_fire_s) begin
                out_valid_d = 1'b1;
                out_data_d  = mask_bytes(i_input_data, i_input_keep);
                out_keep_d  = i_input_keep;
                out_last_d  = (i_input_keep != {IK{1'b1}});
            end else if (out_valid_q && i_output_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

endmodule

// File: tb/tb_axis_data_width_converter.sv
// Directed bench for axis_data_width_converter: three instances (32->64,
// 64->32, 32->32). Output handshakes are collected into queues on the falling
// edge and compared against hand-computed beats.
module tb_axis_data_width_converter;

    logic clk;
    logic rst;

    logic        up_in_valid, up_in_ready, up_out_valid, up_out_ready, up_out_last;
    logic [31:0] up_in_data;
    logic [3:0]  up_in_keep;
    logic [63:0] up_out_data;
    logic [7:0]  up_out_keep;

    logic        dn_in_valid, dn_in_ready, dn_out_valid, dn_out_ready, dn_out_last;
    logic [63:0] dn_in_data;
    logic [7:0]  dn_in_keep;
    logic [31:0] dn_out_data;
    logic [3:0]  dn_out_keep;

    logic        eq_in_valid, eq_in_ready, eq_out_valid, eq_out_ready, eq_out_last;
    logic [31:0] eq_in_data;
    logic [3:0]  eq_in_keep;
    logic [31:0] eq_out_data;
    logic [3:0]  eq_out_keep;

    logic [72:0] up_q[$];
    logic [72:0] dn_q[$];
    logic [72:0] eq_q[$];

    int num_checks = 0;
    int num_errors = 0;

    axis_data_width_converter #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(64)) u_up (
        .i_clk(clk), .i_aresetn(rst),
        .i_input_valid(up_in_valid), .o_input_ready(up_in_ready),
        .i_input_data(up_in_data), .i_input_keep(up_in_keep),
        .o_output_valid(up_out_valid), .i_output_ready(up_out_ready),
        .o_output_last(up_out_last), .o_output_data(up_out_data),
        .o_output_keep(up_out_keep)
    );

    axis_data_width_converter #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(32)) u_dn (
        .i_clk(clk), .i_aresetn(rst),
        .i_input_valid(dn_in_valid), .o_input_ready(dn_in_ready),
        .i_input_data(dn_in_data), .i_input_keep(dn_in_keep),
        .o_output_valid(dn_out_valid), .i_output_ready(dn_out_ready),
        .o_output_last(dn_out_last), .o_output_data(dn_out_data),
        .o_output_keep(dn_out_keep)
    );

    axis_data_width_converter #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(32)) u_eq (
        .i_clk(clk), .i_aresetn(rst),
        .i_input_valid(eq_in_valid), .o_input_ready(eq_in_ready),
        .i_input_data(eq_in_data), .i_input_keep(eq_in_keep),
        .o_output_valid(eq_out_valid), .i_output_ready(eq_out_ready),
        .o_output_last(eq_out_last), .o_output_data(eq_out_data),
        .o_output_keep(eq_out_keep)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every output handshake, sampled away from the rising edge
    always @(negedge clk) begin
        if (up_out_valid && up_out_ready) up_q.push_back({up_out_last, up_out_keep, up_out_data});
        if (dn_out_valid && dn_out_ready) dn_q.push_back({dn_out_last, 4'h0, dn_out_keep, 32'h0, dn_out_data});
        if (eq_out_valid && eq_out_ready) eq_q.push_back({eq_out_last, 4'h0, eq_out_keep, 32'h0, eq_out_data});
    end

    // Hard stop in case something stalls the main sequence
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [72:0] obs,
                              input logic [63:0] d, input logic [7:0] k, input logic l);
        check_value({tag, "_data"}, obs[63:0], d);
        check_value({tag, "_keep"}, 64'(obs[71:64]), 64'(k));
        check_value({tag, "_last"}, 64'(obs[72]), 64'(l));
    endtask

    task automatic send_up(input logic [31:0] d, input logic [3:0] k);
        int n;
        up_in_valid = 1'b1; up_in_data = d; up_in_keep = k; n = 0;
        @(negedge clk);
        while (!up_in_ready && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) check_value("up_send_timeout", 64'(up_in_ready), 64'd1);
        @(posedge clk); #1;
        up_in_valid = 1'b0;
    endtask

    task automatic send_dn(input logic [63:0] d, input logic [7:0] k);
        int n;
        dn_in_valid = 1'b1; dn_in_data = d; dn_in_keep = k; n = 0;
        @(negedge clk);
        while (!dn_in_ready && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) check_value("dn_send_timeout", 64'(dn_in_ready), 64'd1);
        @(posedge clk); #1;
        dn_in_valid = 1'b0;
    endtask

    task automatic send_eq(input logic [31:0] d, input logic [3:0] k);
        int n;
        eq_in_valid = 1'b1; eq_in_data = d; eq_in_keep = k; n = 0;
        @(negedge clk);
        while (!eq_in_ready && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) check_value("eq_send_timeout", 64'(eq_in_ready), 64'd1);
        @(posedge clk); #1;
        eq_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        up_in_valid = 1'b0; up_in_data = 32'h0; up_in_keep = 4'h0; up_out_ready = 1'b1;
        dn_in_valid = 1'b0; dn_in_data = 64'h0; dn_in_keep = 8'h0; dn_out_ready = 1'b1;
        eq_in_valid = 1'b0; eq_in_data = 32'h0; eq_in_keep = 4'h0; eq_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_up_valid", 64'(up_out_valid), 64'd0);
        check_value("rst_up_last",  64'(up_out_last),  64'd0);
        check_value("rst_up_data",  up_out_data,       64'd0);
        check_value("rst_up_keep",  64'(up_out_keep),  64'd0);
        check_value("rst_up_ready", 64'(up_in_ready),  64'd0);
        check_value("rst_dn_valid", 64'(dn_out_valid), 64'd0);
        check_value("rst_dn_ready", 64'(dn_in_ready),  64'd0);
        check_value("rst_eq_valid", 64'(eq_out_valid), 64'd0);
        check_value("rst_eq_ready", 64'(eq_in_ready),  64'd0);
        rst = 1'b0;

        // Upsize: repeated partial beat, one output per input
        up_in_valid = 1'b1; up_in_data = 32'hABCDEFAB; up_in_keep = 4'h7;
        repeat (3) @(posedge clk);
        #1;
        up_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("up_partial_cnt", 64'(up_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (up_q.size() > 0) check_beat("up_partial", up_q.pop_front(), 64'h00000000_00CDEFAB, 8'h07, 1'b1);
        end

        // Upsize: two full beats, then a short beat
        send_up(32'h11111111, 4'hF);
        send_up(32'h22222222, 4'hF);
        send_up(32'h33333333, 4'h3);
        repeat (3) @(posedge clk);
        #1;
        check_value("up_full_cnt", 64'(up_q.size()), 64'd2);
        if (up_q.size() > 0) check_beat("up_full", up_q.pop_front(), 64'h22222222_11111111, 8'hFF, 1'b0);
        if (up_q.size() > 0) check_beat("up_short", up_q.pop_front(), 64'h00000000_00003333, 8'h03, 1'b1);

        // Downsize: full beat splits in two, short beat yields a single slice
        send_dn(64'h89ABCDEF_01234567, 8'hFF);
        send_dn(64'h00000000_00ABCDEF, 8'h07);
        repeat (4) @(posedge clk);
        #1;
        check_value("dn_cnt", 64'(dn_q.size()), 64'd3);
        if (dn_q.size() > 0) check_beat("dn_s0", dn_q.pop_front(), 64'h01234567, 8'h0F, 1'b0);
        if (dn_q.size() > 0) check_beat("dn_s1", dn_q.pop_front(), 64'h89ABCDEF, 8'h0F, 1'b0);
        if (dn_q.size() > 0) check_beat("dn_s2", dn_q.pop_front(), 64'h00ABCDEF, 8'h07, 1'b1);

        // Backpressure on upsize: pending word must hold and block input
        up_out_ready = 1'b0;
        send_up(32'h44444444, 4'hF);
        send_up(32'h55555555, 4'hF);
        up_in_valid = 1'b1; up_in_data = 32'h66666666; up_in_keep = 4'hF;
        repeat (5) begin
            @(negedge clk);
            check_value("bp_valid",    64'(up_out_valid), 64'd1);
            check_value("bp_data",     up_out_data,       64'h55555555_44444444);
            check_value("bp_in_ready", 64'(up_in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        up_out_ready = 1'b1;
        send_up(32'h66666666, 4'hF);
        send_up(32'h77777777, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check_value("bp_cnt", 64'(up_q.size()), 64'd2);
        if (up_q.size() > 0) check_beat("bp_w0", up_q.pop_front(), 64'h55555555_44444444, 8'hFF, 1'b0);
        if (up_q.size() > 0) check_beat("bp_w1", up_q.pop_front(), 64'h77777777_66666666, 8'hFF, 1'b0);

        // Reset mid-packet drops the partial word
        send_up(32'h12345678, 4'hF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("mid_rst_cnt", 64'(up_q.size()), 64'd0);
        send_up(32'h0000000A, 4'hF);
        send_up(32'h0000000B, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check_value("after_rst_cnt", 64'(up_q.size()), 64'd1);
        if (up_q.size() > 0) check_beat("after_rst", up_q.pop_front(), 64'h0000000B_0000000A, 8'hFF, 1'b0);

        // Equal widths: registered pass-through, short keep masks and sets last
        send_eq(32'hDEADBEEF, 4'hF);
        check_value("eq_valid", 64'(eq_out_valid), 64'd1);
        check_value("eq_data",  64'(eq_out_data),  64'hDEADBEEF);
        check_value("eq_keep",  64'(eq_out_keep),  64'hF);
        check_value("eq_last",  64'(eq_out_last),  64'd0);
        send_eq(32'h1234BEEF, 4'h3);
        check_value("eq_p_data", 64'(eq_out_data), 64'h0000BEEF);
        check_value("eq_p_keep", 64'(eq_out_keep), 64'h3);
        check_value("eq_p_last", 64'(eq_out_last), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check_value("eq_cnt", 64'(eq_q.size()), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
